// File: rtl/adder_stage4_2_ctrl.sv
// Sequencer and operand-gating controller for the conv2 stage-4 three-input adder.
// Optional power gating (SLEEP/WAKE, idle counter) is compiled in with ADDER4_POWER_GATE_EN.
module adder_stage4_2_ctrl #(
  parameter int PIXELS_PER_FRAME = 64,
  parameter int IDLE_TIMEOUT     = 8,
  parameter int WAKE_CYCLES      = 2,
  parameter int CW               = $clog2(PIXELS_PER_FRAME)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          adder_enable,
  input  logic          adder_done,
  output logic [CW-1:0] pixel_count,
  output logic          frame_done,
  output logic          power_on,
  output logic          busy,
  output logic          protocol_err
);

  if (PIXELS_PER_FRAME < 2 || IDLE_TIMEOUT < 1 || WAKE_CYCLES < 1) begin : g_bad_params
    $error("adder_stage4_2_ctrl: illegal parameter combination");
  end

  localparam logic [CW-1:0] LAST = CW'(PIXELS_PER_FRAME - 1);

`ifdef ADDER4_POWER_GATE_EN
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SLEEP = 2'd2, WAKE = 2'd3} state_t;

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
`else
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1} state_t;
`endif

  state_t        state;
  logic [CW-1:0] issue_cnt;
  logic          outstanding;
  logic          ignore_done;

  logic accept;
  logic done_seen;
  logic result;
  logic stray;
  logic pix_wrap;
  logic issue_wrap;

  assign in_ready     = (state == RUN);
  assign accept       = in_valid & in_ready;
  assign adder_enable = accept;
  assign busy         = (state != RUN) | outstanding;

  // The adder has no reset, so its done output is untrusted for one cycle after reset.
  assign done_seen  = adder_done & ~ignore_done;
  assign result     = done_seen & outstanding;
  assign stray      = done_seen & ~outstanding;
  assign pix_wrap   = (pixel_count == LAST);
  assign issue_wrap = (issue_cnt == LAST);

`ifndef ADDER4_POWER_GATE_EN
  assign power_on = 1'b1;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      issue_cnt    <= '0;
      pixel_count  <= '0;
      frame_done   <= 1'b0;
      protocol_err <= 1'b0;
      outstanding  <= 1'b0;
      ignore_done  <= 1'b1;
`ifdef ADDER4_POWER_GATE_EN
      power_on     <= 1'b1;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
`endif
    end else begin
      ignore_done <= 1'b0;
      outstanding <= accept;
      frame_done  <= result & pix_wrap;

      if (result) pixel_count <= pix_wrap ? '0 : pixel_count + 1'b1;
      if (stray) protocol_err <= 1'b1;
      if (accept) issue_cnt <= issue_wrap ? '0 : issue_cnt + 1'b1;

      case (state)
        RUN: begin
          if (accept && issue_wrap) state <= DRAIN;
`ifdef ADDER4_POWER_GATE_EN
          if (in_valid) begin
            idle_cnt <= '0;
          end else begin
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            // This idle cycle is the IDLE_TIMEOUT-th; sleep only once the last result is back.
            if (idle_cnt >= IDLE_LAST && !outstanding) begin
              state    <= SLEEP;
              power_on <= 1'b0;
            end
          end
`endif
        end
        DRAIN: begin
          if (result && pix_wrap) state <= RUN;
        end
`ifdef ADDER4_POWER_GATE_EN
        SLEEP: begin
          idle_cnt <= '0;
          if (in_valid) begin
            state    <= WAKE;
            power_on <= 1'b1;
            wake_cnt <= '0;
          end
        end
        WAKE: begin
          if (wake_cnt == WAKE_LAST) state <= RUN;
          else wake_cnt <= wake_cnt + 1'b1;
        end
`endif
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_stage4_2_ctrl.sv
// Self-checking bench for adder_stage4_2_ctrl: directed scenarios plus random traffic
// against a frame/transaction-level reference model. Honours ADDER4_POWER_GATE_EN.
module tb_adder_stage4_2_ctrl;

  localparam int P  = 64;
  localparam int I  = 8;
  localparam int W  = 2;
  localparam int CW = $clog2(P);
`ifdef ADDER4_POWER_GATE_EN
  localparam bit PG = 1'b1;
`else
  localparam bit PG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          adder_enable;
  logic          adder_done;
  logic [CW-1:0] pixel_count;
  logic          frame_done;
  logic          power_on;
  logic          busy;
  logic          protocol_err;

  always #5 clk = ~clk;

  adder_stage4_2_ctrl #(
    .PIXELS_PER_FRAME(P),
    .IDLE_TIMEOUT    (I),
    .WAKE_CYCLES     (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .adder_enable(adder_enable),
    .adder_done  (adder_done),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .power_on    (power_on),
    .busy        (busy),
    .protocol_err(protocol_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model: totals of accepted operands and returned results since reset.
  int n_acc, n_res, m_idle, m_wake;
  bit m_out, m_fd, m_err, m_ign, m_asleep;

  task automatic model_reset();
    n_acc = 0; n_res = 0; m_idle = 0; m_wake = 0;
    m_out = 0; m_fd = 0; m_err = 0; m_ign = 1; m_asleep = 0;
  endtask

  function automatic bit model_run();
    bit draining;
    draining = (n_acc / P) > (n_res / P);
    return !draining && !m_asleep && (m_wake == 0);
  endfunction

  // One clock cycle: drive at negedge, compare all outputs, then advance the model.
  task automatic step(input bit rst, input bit v, input bit spur, input bit drop);
    bit run, acc, done, dv;
    @(negedge clk);
    cyc++;
    done     = (m_out & !drop) | spur;
    reset    = rst;
    in_valid = v;
    adder_done = done;
    #1;
    run = model_run();
    acc = v & run;
    check("in_ready",     32'(in_ready),     32'(run));
    check("adder_enable", 32'(adder_enable), 32'(acc));
    check("pixel_count",  32'(pixel_count),  32'(n_res % P));
    check("frame_done",   32'(frame_done),   32'(m_fd));
    check("power_on",     32'(power_on),     32'(!m_asleep));
    check("busy",         32'(busy),         32'(!run | m_out));
    check("protocol_err", 32'(protocol_err), 32'(m_err));
    if (rst) begin
      model_reset();
    end else begin
      dv = done & !m_ign;
      m_fd = 0;
      if (dv && m_out) begin
        n_res++;
        m_fd = (n_res % P) == 0;
      end
      if (dv && !m_out) m_err = 1;
      if (PG) begin
        if (m_asleep) begin
          m_idle = 0;
          if (v) begin m_asleep = 0; m_wake = W; end
        end else if (m_wake > 0) begin
          m_wake--;
          m_idle = 0;
        end else if (run) begin
          if (v) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle >= I && !m_out) m_asleep = 1;
          end
        end
      end
      m_out = acc;
      if (acc) n_acc++;
      m_ign = 0;
    end
  endtask

  initial begin
    int en_cnt;
    int pc_before;
    reset = 1'b1; in_valid = 1'b0; adder_done = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    #1;
    check("rst_pixel_count",  32'(pixel_count),  0);
    check("rst_frame_done",   32'(frame_done),   0);
    check("rst_power_on",     32'(power_on),     1);
    check("rst_protocol_err", 32'(protocol_err), 0);
    check("rst_in_ready",     32'(in_ready),     1);

    // Full frame with in_valid held high from cycle 0.
    en_cnt = 0;
    for (int k = 0; k <= 65; k++) begin
      step(0, 1, 0, 0);
      if (k < 64) en_cnt += int'(adder_enable);
      if (k == 64) check("full_drain_ready", 32'(in_ready), 0);
      if (k == 65) begin
        check("full_frame_done", 32'(frame_done),  1);
        check("full_pix_wrap",   32'(pixel_count), 0);
        check("full_ready_back", 32'(in_ready),    1);
      end
    end
    check("full_enable_pulses", 32'(en_cnt), 64);

    // Sparse input: accept every other cycle.
    step(1, 0, 0, 0);
    for (int k = 0; k < 130; k++) begin
      step(0, (k % 2) == 0, 0, 0);
      if (k == 128) check("sparse_frame_done", 32'(frame_done), 1);
    end
    check("sparse_no_err", 32'(protocol_err), 0);

    // Idle to sleep and wake: last accept in cycle 10, in_valid back in cycle 25.
    step(1, 0, 0, 0);
    for (int k = 0; k <= 35; k++) begin
      step(0, (k <= 10) || (k >= 25), 0, 0);
      if (k == 18) check("idle_power_18", 32'(power_on), 1);
      if (k == 19) check("idle_power_19", 32'(power_on), 32'(!PG));
      if (k == 24) check("idle_pix_kept", 32'(pixel_count), 11);
      if (k == 26) check("wake_power_26", 32'(power_on), 1);
      if (k == 27) check("wake_ready_27", 32'(in_ready), 32'(!PG));
      if (k == 28) check("wake_accept_28", 32'(adder_enable), 1);
    end

    // Spurious done with nothing outstanding.
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    pc_before = int'(pixel_count);
    step(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      check("spur_err_sticky", 32'(protocol_err), 1);
      check("spur_pix_same",   32'(pixel_count),  32'(pc_before));
    end

    // Missing done at the end of a frame leaves the controller in DRAIN.
    step(1, 0, 0, 0);
    for (int k = 0; k < 64; k++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      check("drain_hold_ready", 32'(in_ready), 0);
    end

    // Reset in cycle 20 of a frame, with a done in the first post-reset cycle.
    step(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);
    check("mid_rst_pix",   32'(pixel_count),  0);
    check("mid_rst_err",   32'(protocol_err), 0);
    check("mid_rst_power", 32'(power_on),     1);
    check("mid_rst_ready", 32'(in_ready),     1);
    step(0, 0, 0, 0);
    check("post_rst_done_ignored_err", 32'(protocol_err), 0);
    check("post_rst_done_ignored_pix", 32'(pixel_count),  0);

    // Random traffic in segments of varying density.
    step(1, 0, 0, 0);
    for (int seg = 0; seg < 30; seg++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int k = 0; k < 100; k++) begin
        bit r, v, s, d;
        r = ($urandom_range(0, 299) == 0);
        v = ($urandom_range(0, 99) < dens);
        s = ($urandom_range(0, 299) == 0);
        d = ($urandom_range(0, 1499) == 0);
        step(r, v, s, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
